prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that fills the CPU's instruction memory before execution and releases the core when the image is verified. It sits between an external byte source (UART RX or bench driver) and the instruction-memory write port. It holds the pipeline frozen during a load and issues a one-cycle core reset on release. It is the writer-side counterpart to the bench-side register/memory dump: it drives state into the core instead of observing it.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width.
- `MAX_WORDS`, default 1024: largest accepted image length, in 32-bit words.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `RX_DATA` in 8: incoming byte.
- `RX_VALID` in 1: `RX_DATA` is valid this cycle.
- `RX_READY` out 1: loader accepts a byte this cycle. Equals `~RST`; a byte transfers on an edge where `RX_VALID & RX_READY`.
- `IM_WE` out 1: instruction-memory write strobe; one-cycle pulse per word.
- `IM_ADDR` out `ADDR_W`: word address for the write.
- `IM_WDATA` out 32: word to write.
- `CPU_HOLD` out 1: freezes the CPU pipeline while high.
- `CPU_RST` out 1: one-cycle core reset pulse on release.
- `DONE` out 1: last load verified and core released.
- `ERR` out 1: last load failed (length or checksum).

## Operation
- Frame format: `0xA5`, then LEN_LO, LEN_HI (16-bit word count, little-endian), then 4·LEN data bytes, then a checksum byte (XOR of all data bytes only).
- Each group of 4 data bytes forms one little-endian word: the first byte goes to `[7:0]`. Words are written to `IM_ADDR` 0, 1, 2, … in order.
- States:
  - IDLE: non-`0xA5` bytes are discarded. `0xA5` → LEN_LO. On that transfer, set `CPU_HOLD=1` and clear `DONE` and `ERR`.
  - LEN_LO → LEN_HI.
  - LEN_HI:
    - LEN > `MAX_WORDS` → ERRST.
    - LEN = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: after the 4·LEN-th byte → CSUM. A `0xA5` byte inside DATA is data, never a resync.
  - CSUM: byte equals the running XOR → RELEASE; otherwise → ERRST.
  - RELEASE: lasts one cycle; asserts `CPU_RST`, then → RUN.
  - RUN: `DONE=1`, `CPU_HOLD=0`. A `0xA5` starts a new load, behaving as in IDLE.
  - ERRST: `ERR=1`, `CPU_HOLD=1`. Other bytes are ignored; `0xA5` restarts at LEN_LO.
- Words are written before the checksum is checked. On failure the hold stays asserted, so an unverified image never executes.
- The word counter is `ADDR_W+1` bits wide so that `MAX_WORDS` does not wrap. The running XOR and byte index clear on every sync byte.
- Reset values:
  - State is IDLE.
  - `CPU_HOLD=1`; `CPU_RST`, `IM_WE`, `DONE`, `ERR` are 0.
  - `IM_ADDR` and `IM_WDATA` are 0; the word counter and XOR are 0.
- `RST` mid-load abandons the frame completely. The next load starts at address 0. No partial word is written.

## Timing
- The 4th byte of a word is accepted on edge k. `IM_WE`, `IM_ADDR` and `IM_WDATA` are registered and valid during cycle k→k+1; memory samples on edge k+1. `IM_WE` is never high for two consecutive cycles.
- The checksum byte is accepted on edge k.
  - On success, `CPU_RST=1` during cycle k→k+1. `CPU_HOLD` falls and `DONE` rises after edge k+1.
  - On failure, `ERR` rises after edge k.
- The length check happens on the LEN_HI edge. `ERR` is visible the next cycle, with no `IM_WE`.
- Gaps in `RX_VALID` stall the FSM with no timeouts; outputs hold their values.

## Structure
- Shared package `prog_loader_pkg` holds:
  - the `SYNC_BYTE` = `8'hA5` constant;
  - the state encoding (IDLE, LEN_LO, LEN_HI, DATA, CSUM, RELEASE, RUN, ERRST).
- Sub-module `prog_loader_asm`: 2-bit byte index plus a 32-bit shift/assemble register. It emits `word_valid` and `word` for the FSM, which registers them onto the memory port.

## Test plan
- Good load: bytes A5 02 00 13 00 00 00 93 00 10 00 90 → two `IM_WE` pulses: addr 0 = `0x00000013`, addr 1 = `0x00100093`. Then `CPU_RST` pulses once, `CPU_HOLD`→0 and `DONE`=1.
- Bad checksum: same frame ending in 91 → `ERR`=1, `CPU_HOLD` stays 1, no `CPU_RST`. Resending the good frame then yields `DONE`=1, `ERR`=0.
- Oversize: A5 01 04 (LEN=1025, `MAX_WORDS`=1024) → `ERR` the cycle after LEN_HI, no `IM_WE`. Further data bytes are ignored.
- Noise and gaps: 00 FF 3C before A5, with `RX_VALID` low on random cycles → noise is ignored and the writes are identical to the good load.
- Reset mid-DATA: assert `RST` after 6 data bytes → outputs return to reset values. A new good frame writes starting at addr 0.
- Empty image: A5 00 00 00 → no `IM_WE`, one `CPU_RST` pulse, `DONE`=1. A following A5 re-asserts `CPU_HOLD` and clears `DONE`.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants and state encoding for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Frame start marker; also the only byte that matters outside a frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader state encoding.
    localparam int         STATE_W    = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN_LO  = 3'd1;
    localparam logic [2:0] ST_LEN_HI  = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;
    localparam logic [2:0] ST_RELEASE = 3'd5;
    localparam logic [2:0] ST_RUN     = 3'd6;
    localparam logic [2:0] ST_ERRST   = 3'd7;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_asm.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_asm
// Description : Assembles four data bytes into one little-endian 32-bit word.
//               word/word_valid are combinational on the 4th byte so the
//               loader FSM can register them onto the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    // Byte index and the first three bytes of the word in flight; the oldest
    // byte sits lowest so the finished word comes out little-endian.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clr) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_byte_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    assign word_valid = i_byte_valid & (r_idx == 2'd3);
    assign word       = {i_byte, r_shift};

endmodule : prog_loader_asm
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-stream program loader. Parses A5/LEN/data/XOR frames,
//               writes words into instruction memory while holding the core,
//               and releases it with a one-cycle reset once the image checks.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              IM_WE,
    output logic [ADDR_W-1:0] IM_ADDR,
    output logic [31:0]       IM_WDATA,
    output logic              CPU_HOLD,
    output logic              CPU_RST,
    output logic              DONE,
    output logic              ERR
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_wcnt;      // one bit wider so MAX_WORDS does not wrap
    logic [7:0]        r_xor;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic              w_is_sync;
    logic              w_sync_xfer;
    logic              w_data_byte;
    logic [15:0]       w_len;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_wcnt_inc;
    logic              w_last_word;
    logic              w_csum_ok;
    logic              w_word_valid;
    logic [31:0]       w_word;

    assign w_xfer      = RX_VALID & ~RST;
    assign w_is_sync   = (RX_DATA == SYNC_BYTE);
    assign w_data_byte = w_xfer & (r_state == ST_DATA);
    assign w_len       = {RX_DATA, r_len[7:0]};
    assign w_len_bad   = (w_len > 16'(MAX_WORDS));
    assign w_wcnt_inc  = r_wcnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word = w_word_valid & (16'(w_wcnt_inc) == r_len);
    assign w_csum_ok   = (RX_DATA == r_xor);

    prog_loader_asm u_asm (
        .clk          (CLK),
        .rst          (RST),
        .i_clr        (w_sync_xfer),
        .i_byte_valid (w_data_byte),
        .i_byte       (RX_DATA),
        .word_valid   (w_word_valid),
        .word         (w_word)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a sync byte only resynchronises outside a frame.
    always_comb begin
        w_state_nxt = r_state;
        w_sync_xfer = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERRST: begin
                if (w_xfer && w_is_sync) begin
                    w_state_nxt = ST_LEN_LO;
                    w_sync_xfer = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_bad)          w_state_nxt = ST_ERRST;
                    else if (w_len == 16'd0) w_state_nxt = ST_CSUM;
                    else                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_last_word) w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_xfer) w_state_nxt = w_csum_ok ? ST_RELEASE : ST_ERRST;
            end
            ST_RELEASE: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs: length capture, running XOR, memory
    // write port and the hold/release/status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_len     <= 16'd0;
            r_wcnt    <= '0;
            r_xor     <= 8'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_hold    <= 1'b1;
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_cpu_rst <= 1'b0;
            if (w_sync_xfer) begin
                r_hold <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 1'b0;
                r_xor  <= 8'd0;
                r_wcnt <= '0;
            end
            if (w_xfer && (r_state == ST_LEN_LO)) begin
                r_len[7:0] <= RX_DATA;
            end
            if (w_xfer && (r_state == ST_LEN_HI)) begin
                r_len[15:8] <= RX_DATA;
                if (w_len_bad) r_err <= 1'b1;
            end
            if (w_data_byte) begin
                r_xor <= r_xor ^ RX_DATA;
                if (w_word_valid) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_wcnt[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_wcnt  <= w_wcnt_inc;
                end
            end
            if (w_xfer && (r_state == ST_CSUM)) begin
                if (w_csum_ok) r_cpu_rst <= 1'b1;
                else           r_err     <= 1'b1;
            end
            if (r_state == ST_RELEASE) begin
                r_hold <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign RX_READY = ~RST;
    assign IM_WE    = r_we;
    assign IM_ADDR  = r_addr;
    assign IM_WDATA = r_wdata;
    assign CPU_HOLD = r_hold;
    assign CPU_RST  = r_cpu_rst;
    assign DONE     = r_done;
    assign ERR      = r_err;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed, self-checking bench for prog_loader with a write
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic              IM_WE;
    logic [ADDR_W-1:0] IM_ADDR;
    logic [31:0]       IM_WDATA;
    logic              CPU_HOLD;
    logic              CPU_RST;
    logic              DONE;
    logic              ERR;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .IM_WE    (IM_WE),
        .IM_ADDR  (IM_ADDR),
        .IM_WDATA (IM_WDATA),
        .CPU_HOLD (CPU_HOLD),
        .CPU_RST  (CPU_RST),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_crst = 0;
    int         n_we = 0;
    logic       prev_we = 1'b0;
    int         crst0;
    int         we0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and retire any memory write
    // against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge CLK);
        #1;
        if (IM_WE === 1'b1) begin
            n_we++;
            chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
            chk("write_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("im_addr", {22'd0, IM_ADDR}, {22'd0, e.a});
                chk("im_wdata", IM_WDATA, e.d);
            end
        end
        prev_we = IM_WE;
        if (CPU_RST === 1'b1) n_crst++;
    endtask

    task automatic send_tx(input int gmax);
        int g;
        while (tx.size() != 0) begin
            g = int'($urandom_range(gmax, 0));
            RX_VALID = 1'b0;
            repeat (g) tick();
            RX_DATA  = tx.pop_front();
            RX_VALID = 1'b1;
            tick();
            RX_VALID = 1'b0;
        end
    endtask

    task automatic push_good_writes();
        exp_q.push_back('{a: 10'd0, d: 32'h0000_0013});
        exp_q.push_back('{a: 10'd1, d: 32'h0010_0093});
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_hold"},  {31'd0, CPU_HOLD}, 32'd1);
        chk({pfx, "_crst"},  {31'd0, CPU_RST},  32'd0);
        chk({pfx, "_we"},    {31'd0, IM_WE},    32'd0);
        chk({pfx, "_done"},  {31'd0, DONE},     32'd0);
        chk({pfx, "_err"},   {31'd0, ERR},      32'd0);
        chk({pfx, "_addr"},  {22'd0, IM_ADDR},  32'd0);
        chk({pfx, "_wdata"}, IM_WDATA,          32'd0);
        chk({pfx, "_ready"}, {31'd0, RX_READY}, 32'd0);
    endtask

    // Full good frame followed by the release sequence checks.
    task automatic good_load(input string pfx, input int gmax);
        crst0 = n_crst;
        we0   = n_we;
        push_good_writes();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_tx(gmax);
        chk({pfx, "_rel_crst"}, {31'd0, CPU_RST},  32'd1);
        chk({pfx, "_rel_hold"}, {31'd0, CPU_HOLD}, 32'd1);
        chk({pfx, "_rel_done"}, {31'd0, DONE},     32'd0);
        chk({pfx, "_drained"},  exp_q.size(),      32'd0);
        tick();
        chk({pfx, "_run_crst"}, {31'd0, CPU_RST},  32'd0);
        chk({pfx, "_run_hold"}, {31'd0, CPU_HOLD}, 32'd0);
        chk({pfx, "_run_done"}, {31'd0, DONE},     32'd1);
        chk({pfx, "_run_err"},  {31'd0, ERR},      32'd0);
        chk({pfx, "_crst_cnt"}, n_crst - crst0,    32'd1);
        chk({pfx, "_we_cnt"},   n_we - we0,        32'd2);
    endtask

    initial begin
        RST      = 1'b1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        repeat (3) tick();
        check_reset_values("reset");
        RST = 1'b0;
        tick();
        chk("ready_after_reset", {31'd0, RX_READY}, 32'd1);

        // Good load.
        good_load("good", 0);

        // Bad checksum: words still land, core stays held.
        tx = '{8'hA5};
        send_tx(0);
        chk("bad_sync_hold", {31'd0, CPU_HOLD}, 32'd1);
        chk("bad_sync_done", {31'd0, DONE},     32'd0);
        crst0 = n_crst;
        push_good_writes();
        tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        send_tx(0);
        chk("bad_err",  {31'd0, ERR},      32'd1);
        chk("bad_hold", {31'd0, CPU_HOLD}, 32'd1);
        chk("bad_crst", {31'd0, CPU_RST},  32'd0);
        repeat (3) tick();
        chk("bad_no_release", n_crst - crst0, 32'd0);
        chk("bad_err_held",   {31'd0, ERR},   32'd1);
        chk("bad_drained",    exp_q.size(),   32'd0);
        good_load("retry", 0);

        // Oversize length: LEN = 1025.
        we0 = n_we;
        tx  = '{8'hA5, 8'h01, 8'h04};
        send_tx(0);
        chk("over_err",  {31'd0, ERR},      32'd1);
        chk("over_hold", {31'd0, CPU_HOLD}, 32'd1);
        chk("over_we",   {31'd0, IM_WE},    32'd0);
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_tx(0);
        chk("over_no_writes", n_we - we0,     32'd0);
        chk("over_err_held",  {31'd0, ERR},   32'd1);

        // Noise before sync and random valid gaps.
        tx = '{8'h00, 8'hFF, 8'h3C};
        send_tx(2);
        chk("noise_ignored", {31'd0, ERR}, 32'd1);
        good_load("gaps", 3);

        // Reset in the middle of DATA after six data bytes.
        exp_q.push_back('{a: 10'd0, d: 32'h0000_0013});
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send_tx(0);
        chk("mid_first_word", exp_q.size(), 32'd0);
        RST = 1'b1;
        tick();
        tick();
        check_reset_values("midrst");
        RST = 1'b0;
        tick();
        good_load("after_rst", 1);

        // Empty image.
        crst0 = n_crst;
        we0   = n_we;
        tx    = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx(0);
        chk("empty_crst", {31'd0, CPU_RST}, 32'd1);
        tick();
        chk("empty_done",     {31'd0, DONE},     32'd1);
        chk("empty_hold",     {31'd0, CPU_HOLD}, 32'd0);
        chk("empty_no_write", n_we - we0,        32'd0);
        chk("empty_one_crst", n_crst - crst0,    32'd1);
        tx = '{8'hA5};
        send_tx(0);
        chk("resync_hold", {31'd0, CPU_HOLD}, 32'd1);
        chk("resync_done", {31'd0, DONE},     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
